// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program-counter sequencer.
//
// Each cycle the next fetch address is chosen from four sources:
//   - sequential PC+1
//   - the jump/branch target
//   - the call target
//   - the return address presented by subroutine_stack
// The sequencer also issues the push/pop pulses that drive subroutine_stack,
// supplies the link address to push, and tracks how many entries are live.
//
// Optional build macro: STACK_GUARD_EN
//   When defined, a call at full depth or a return at zero depth is dropped:
//   no pulse is issued and fetch simply advances to PC+1.
//   When undefined, such a call or return goes to the stack as usual, and the
//   stack pointer wraps inside the stack.
//   The sticky error flags are set in both builds.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   stall               hold all state; no pulses issued
//   is_call/is_ret      decoded CALL / RET at the current PC
//   is_jump             unconditional jump or taken branch
//   target_adr          jump/call destination
//   RTS_adr             registered return address from subroutine_stack
//   PC                  current fetch address
//   link_adr            PC+1, the address pushed on a call
//   subroutine_call     one-cycle push pulse
//   subroutine_return   one-cycle pop pulse
//   ret_busy            high while waiting for the return address
//   stack_depth         live stack entries, 0..STACK_DEPTH
//   stack_overflow      sticky: call seen at full depth
//   stack_underflow     sticky: ret seen at zero depth
module pc_sequencer #(
  parameter int                ADDR_W       = 12,
  parameter int                STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              is_jump,
  input  logic [ADDR_W-1:0] target_adr,
  input  logic [ADDR_W-1:0] RTS_adr,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] link_adr,
  output logic              subroutine_call,
  output logic              subroutine_return,
  output logic              ret_busy,
  output logic [3:0]        stack_depth,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  typedef enum logic [0:0] {FETCH, RET_WAIT} state_t;

  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              call_reg, call_next;
  logic              ret_reg, ret_next;
  logic [3:0]        depth_reg, depth_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              depth_full, depth_empty;

  // PC+1 wraps naturally at 2^ADDR_W.
  assign link_adr    = pc_reg + ADDR_W'(1);
  assign depth_full  = (depth_reg == DEPTH_MAX);
  assign depth_empty = (depth_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    call_next  = 1'b0;
    ret_next   = 1'b0;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;

    if (!stall) begin
      case (state_reg)
        FETCH: begin
          if (is_ret) begin
            if (depth_empty) unf_next = 1'b1;
`ifdef STACK_GUARD_EN
            if (depth_empty) begin
              pc_next = link_adr;
            end else begin
              ret_next   = 1'b1;
              state_next = RET_WAIT;
              depth_next = depth_reg - 4'd1;
            end
`else
            // PC is held; the return address arrives from the stack next cycle.
            ret_next   = 1'b1;
            state_next = RET_WAIT;
            if (!depth_empty) depth_next = depth_reg - 4'd1;
`endif
          end else if (is_call) begin
            if (depth_full) ovf_next = 1'b1;
`ifdef STACK_GUARD_EN
            if (depth_full) begin
              pc_next = link_adr;
            end else begin
              call_next  = 1'b1;
              pc_next    = target_adr;
              depth_next = depth_reg + 4'd1;
            end
`else
            call_next = 1'b1;
            pc_next   = target_adr;
            if (!depth_full) depth_next = depth_reg + 4'd1;
`endif
          end else if (is_jump) begin
            pc_next = target_adr;
          end else begin
            pc_next = link_adr;
          end
        end
        RET_WAIT: begin
          // The stack has popped by now, so RTS_adr holds the return address.
          pc_next    = RTS_adr;
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_VECTOR;
      call_reg  <= 1'b0;
      ret_reg   <= 1'b0;
      depth_reg <= 4'd0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      call_reg  <= call_next;
      ret_reg   <= ret_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  assign PC                = pc_reg;
  assign subroutine_call   = call_reg;
  assign subroutine_return = ret_reg;
  assign ret_busy          = (state_reg == RET_WAIT);
  assign stack_depth       = depth_reg;
  assign stack_overflow    = ovf_reg;
  assign stack_underflow   = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer.
// Each scenario task builds a table of per-cycle stimulus and the expected
// outputs. The expected outputs go through a scoreboard queue and are compared
// one cycle at a time. The bench drives RTS_adr itself, acting as the
// subroutine stack by presenting the return address it expects on each pop.
module tb_pc_sequencer;

  typedef struct packed {
    logic        rst, stall, call, ret, jump;
    logic [11:0] tgt, rts;
  } stim_t;

  typedef struct packed {
    logic [11:0] pc;
    logic        c, r, b;
    logic [3:0]  d;
    logic        o, u;
  } obs_t;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, stall, is_call, is_ret, is_jump;
  logic [11:0] target_adr, RTS_adr;
  logic [11:0] PC, link_adr;
  logic        subroutine_call, subroutine_return, ret_busy;
  logic [3:0]  stack_depth;
  logic        stack_overflow, stack_underflow;

  obs_t  sb_q[$];
  stim_t tbl_st[$];
  obs_t  tbl_ex[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(8), .RESET_VECTOR(12'h000)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .is_call(is_call), .is_ret(is_ret), .is_jump(is_jump),
    .target_adr(target_adr), .RTS_adr(RTS_adr),
    .PC(PC), .link_adr(link_adr),
    .subroutine_call(subroutine_call), .subroutine_return(subroutine_return),
    .ret_busy(ret_busy), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  function automatic stim_t mk(logic rst, logic st, logic c, logic r, logic j,
                               logic [11:0] t, logic [11:0] rts);
    return {rst, st, c, r, j, t, rts};
  endfunction

  function automatic obs_t ex(logic [11:0] pc, logic c, logic r, logic b,
                              logic [3:0] d, logic o, logic u);
    return {pc, c, r, b, d, o, u};
  endfunction

  function automatic obs_t sample();
    return {PC, subroutine_call, subroutine_return, ret_busy, stack_depth,
            stack_overflow, stack_underflow};
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("pc=%h call=%b ret=%b busy=%b depth=%0d ovf=%b unf=%b",
                     v.pc, v.c, v.r, v.b, v.d, v.o, v.u);
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    tbl_st.push_back(s);
    tbl_ex.push_back(e);
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic apply(input stim_t s);
    {reset, stall, is_call, is_ret, is_jump, target_adr, RTS_adr} = s;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(1,0,1,0,1,12'h123,0), ex(12'h000,0,0,0,0,0,0));
    add(mk(1,0,0,1,0,12'h000,0), ex(12'h000,0,0,0,0,0,0));
    for (int k = 1; k <= 4; k++)
      add(mk(0,0,0,0,0,0,0), ex(12'(k),0,0,0,0,0,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_reset step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    $display("test_reset: %0d cycles checked", tbl_st.size());
  endtask

  task automatic test_call_ret();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(0,0,0,0,1,12'h010,0),     ex(12'h010,0,0,0,0,0,0));
    add(mk(0,0,1,0,0,12'h200,0),     ex(12'h200,1,0,0,1,0,0));
    add(mk(0,0,0,1,0,0,12'h011),     ex(12'h200,0,1,1,0,0,0));
    add(mk(0,0,0,0,0,0,12'h011),     ex(12'h011,0,0,0,0,0,0));
    add(mk(0,0,0,0,0,0,0),           ex(12'h012,0,0,0,0,0,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_call_ret step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      if (i == 0) begin
        n_checks++;
        if (link_adr !== 12'h011) begin
          n_fail++;
          $display("FAIL test_call_ret link_adr: got %h, expected 011", link_adr);
        end
      end
    end
    $display("test_call_ret: %0d cycles checked", tbl_st.size());
  endtask

  task automatic test_nested();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(0,0,0,0,1,12'h100,0),     ex(12'h100,0,0,0,0,0,0));
    add(mk(0,0,0,0,0,0,0),           ex(12'h101,0,0,0,0,0,0));
    add(mk(0,0,1,0,0,12'h200,0),     ex(12'h200,1,0,0,1,0,0));
    add(mk(0,0,0,0,0,0,0),           ex(12'h201,0,0,0,1,0,0));
    add(mk(0,0,1,0,0,12'h300,0),     ex(12'h300,1,0,0,2,0,0));
    add(mk(0,0,0,1,0,0,12'h202),     ex(12'h300,0,1,1,1,0,0));
    // Decode inputs asserted during the wait cycle must be ignored.
    add(mk(0,0,1,1,1,12'h777,12'h202), ex(12'h202,0,0,0,1,0,0));
    add(mk(0,0,0,1,0,0,12'h102),     ex(12'h202,0,1,1,0,0,0));
    add(mk(0,0,0,0,0,0,12'h102),     ex(12'h102,0,0,0,0,0,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_nested step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    $display("test_nested: %0d cycles checked", tbl_st.size());
  endtask

  task automatic test_priority_stall();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(0,0,1,0,1,12'h400,0),     ex(12'h400,1,0,0,1,0,0));
    add(mk(0,0,1,1,1,12'h500,12'h103), ex(12'h400,0,1,1,0,0,0));
    for (int k = 0; k < 3; k++)
      add(mk(0,1,1,1,1,12'h600,12'h103), ex(12'h400,0,0,1,0,0,0));
    add(mk(0,0,0,0,0,0,12'h103),     ex(12'h103,0,0,0,0,0,0));
    add(mk(0,1,1,0,0,12'h700,0),     ex(12'h103,0,0,0,0,0,0));
    add(mk(0,0,0,0,0,0,0),           ex(12'h104,0,0,0,0,0,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_priority_stall step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    $display("test_priority_stall: %0d cycles checked", tbl_st.size());
  endtask

  task automatic test_overflow();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(1,0,0,0,0,0,0), ex(12'h000,0,0,0,0,0,0));
    add(mk(0,0,0,0,0,0,0), ex(12'h001,0,0,0,0,0,0));
    // Eight calls fill the stack; each target is followed by one idle cycle.
    for (int k = 1; k <= 8; k++) begin
      add(mk(0,0,1,0,0,12'(k*16),0), ex(12'(k*16),1,0,0,4'(k),0,0));
      add(mk(0,0,0,0,0,0,0),         ex(12'(k*16+1),0,0,0,4'(k),0,0));
    end
    add(mk(0,0,1,0,0,12'h090,0),
        GUARD ? ex(12'h082,0,0,0,8,1,0) : ex(12'h090,1,0,0,8,1,0));
    add(mk(0,0,0,0,0,0,0),
        GUARD ? ex(12'h083,0,0,0,8,1,0) : ex(12'h091,0,0,0,8,1,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_overflow step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    $display("test_overflow: %0d cycles checked", tbl_st.size());
  endtask

  task automatic test_underflow_wrap();
    obs_t got, want;
    tbl_st.delete(); tbl_ex.delete();
    add(mk(1,0,0,0,0,0,0), ex(12'h000,0,0,0,0,0,0));
    add(mk(0,0,0,1,0,0,12'h055),
        GUARD ? ex(12'h001,0,0,0,0,0,1) : ex(12'h000,0,1,1,0,0,1));
    add(mk(0,0,0,0,0,0,12'h055),
        GUARD ? ex(12'h002,0,0,0,0,0,1) : ex(12'h055,0,0,0,0,0,1));
    add(mk(0,0,0,0,1,12'hFFF,0),     ex(12'hFFF,0,0,0,0,0,1));
    add(mk(0,0,0,0,0,0,0),           ex(12'h000,0,0,0,0,0,1));
    add(mk(0,0,1,0,0,12'h3A0,0),     ex(12'h3A0,1,0,0,1,0,1));
    add(mk(0,0,0,1,0,0,12'h001),     ex(12'h3A0,0,1,1,0,0,1));
    // Reset lands while waiting for the return address.
    add(mk(1,0,0,0,0,0,12'h001),     ex(12'h000,0,0,0,0,0,0));
    add(mk(0,0,0,0,0,0,0),           ex(12'h001,0,0,0,0,0,0));
    for (int i = 0; i < tbl_st.size(); i++) begin
      sb_q.push_back(tbl_ex[i]);
      apply(tbl_st[i]);
      got  = sample();
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_underflow_wrap step %0d: got %s, expected %s", i, fmt(got), fmt(want));
      end
      if (i == 3) begin
        n_checks++;
        if (link_adr !== 12'h000) begin
          n_fail++;
          $display("FAIL test_underflow_wrap link_adr: got %h, expected 000", link_adr);
        end
      end
    end
    $display("test_underflow_wrap: %0d cycles checked", tbl_st.size());
  endtask

  initial begin
    {reset, stall, is_call, is_ret, is_jump} = 5'b10000;
    target_adr = '0;
    RTS_adr    = '0;
    test_reset();
    test_call_ret();
    test_nested();
    test_priority_stall();
    test_overflow();
    test_underflow_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
